// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index type and pipeline controller state encoding.
// Optional performance counters in pipeline_ctrl are enabled by PIPELINE_CTRL_PERF_EN.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } ctrl_state_t;

  localparam int PERF_W = 32;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/stall bundle between the datapath (master) and pipeline_ctrl (slave).
// PIPELINE_CTRL_PERF_EN adds the stall_cycles / flush_count counter outputs.
interface pipeline_ctrl_if;
  import cpu_types_pkg::*;

  logic     ihit;
  logic     dhit;
  logic     mem_dREN;
  logic     mem_dWEN;
  logic     ex_dREN;
  regbits_t ex_rt;
  regbits_t id_rs;
  regbits_t id_rt;
  logic     mem_redirect;
  logic     wb_halt;

  logic     pc_en;
  logic     en_ifid;
  logic     en_idex;
  logic     en_exmem;
  logic     en_memwb;
  logic     flush_ifid;
  logic     flush_idex;
  logic     flush_exmem;
  logic     halted;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] flush_count;
`endif

  modport master (
    output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_rt, id_rs, id_rt,
           mem_redirect, wb_halt,
`ifdef PIPELINE_CTRL_PERF_EN
    input  stall_cycles, flush_count,
`endif
    input  pc_en, en_ifid, en_idex, en_exmem, en_memwb,
           flush_ifid, flush_idex, flush_exmem, halted
  );

  modport slave (
    input  ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_rt, id_rs, id_rt,
           mem_redirect, wb_halt,
`ifdef PIPELINE_CTRL_PERF_EN
    output stall_cycles, flush_count,
`endif
    output pc_en, en_ifid, en_idex, en_exmem, en_memwb,
           flush_ifid, flush_idex, flush_exmem, halted
  );

endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Combinational load-use hazard detect: load in ID/EX whose destination feeds IF/ID.
module load_use_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_dREN,
  input  regbits_t ex_rt,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  output logic     hazard
);

  // $0 is hardwired zero, so a load targeting it never creates a dependency
  assign hazard = ex_dREN && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline stall/flush controller with zero-cycle combinational reaction.
// Define PIPELINE_CTRL_PERF_EN to add saturating stall_cycles / flush_count counters.
//
// state    | meaning
// RUN      | normal flow; redirects and load-use stalls handled in-cycle
// MEM_WAIT | previous cycle stalled on ihit/dhit; a redirect may be pending
// HALTED   | halt retired; pipeline frozen until RST
module pipeline_ctrl
  import cpu_types_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  pipeline_ctrl_if.slave  bus
);

  ctrl_state_t state;
  logic        flush_pending;
  logic        mem_wait;
  logic        hazard;
  logic        redirect_fire;

  logic pc_en, en_ifid, en_idex, en_exmem, en_memwb;
  logic flush_ifid, flush_idex, flush_exmem;

  load_use_detect u_load_use_detect (
    .ex_dREN (bus.ex_dREN),
    .ex_rt   (bus.ex_rt),
    .id_rs   (bus.id_rs),
    .id_rt   (bus.id_rt),
    .hazard  (hazard)
  );

  assign mem_wait = !bus.ihit || ((bus.mem_dREN || bus.mem_dWEN) && !bus.dhit);

  always_comb begin
    pc_en         = 1'b0;
    en_ifid       = 1'b0;
    en_idex       = 1'b0;
    en_exmem      = 1'b0;
    en_memwb      = 1'b0;
    flush_ifid    = 1'b0;
    flush_idex    = 1'b0;
    flush_exmem   = 1'b0;
    redirect_fire = 1'b0;
    if (state == HALTED || mem_wait) begin
      // everything frozen
    end else if (bus.mem_redirect || flush_pending) begin
      // flushed stages stay enabled so the bubble is actually loaded
      pc_en         = 1'b1;
      en_ifid       = 1'b1;
      en_idex       = 1'b1;
      en_exmem      = 1'b1;
      en_memwb      = 1'b1;
      flush_ifid    = 1'b1;
      flush_idex    = 1'b1;
      flush_exmem   = 1'b1;
      redirect_fire = 1'b1;
    end else if (hazard) begin
      en_idex    = 1'b1;
      en_exmem   = 1'b1;
      en_memwb   = 1'b1;
      flush_idex = 1'b1;
    end else begin
      pc_en    = 1'b1;
      en_ifid  = 1'b1;
      en_idex  = 1'b1;
      en_exmem = 1'b1;
      en_memwb = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= RUN;
      flush_pending <= 1'b0;
    end else if (state != HALTED) begin
      if (bus.wb_halt)
        state <= HALTED;
      else if (mem_wait)
        state <= MEM_WAIT;
      else
        state <= RUN;

      if (mem_wait) begin
        if (bus.mem_redirect)
          flush_pending <= 1'b1;
      end else begin
        flush_pending <= 1'b0;
      end
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.en_ifid     = en_ifid;
  assign bus.en_idex     = en_idex;
  assign bus.en_exmem    = en_exmem;
  assign bus.en_memwb    = en_memwb;
  assign bus.flush_ifid  = flush_ifid;
  assign bus.flush_idex  = flush_idex;
  assign bus.flush_exmem = flush_exmem;
  assign bus.halted      = (state == HALTED);

`ifdef PIPELINE_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] flush_count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_en && state != HALTED && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (redirect_fire && flush_count != '1)
        flush_count <= flush_count + 1'b1;
    end
  end

  assign bus.stall_cycles = stall_cycles;
  assign bus.flush_count  = flush_count;
`endif

endmodule
